// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: two-stage elastic shift/rotate unit for the EX stage.
// Stage 1 latches operands and recasts every operation as a cyclic left rotate
// plus a fill mask. Stage 2 rotates, applies the mask (and sign fill for SRA),
// and holds the result on the output registers until downstream accepts it.
module shift_unit_pipe #(
    parameter int unsigned N     = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [N-1:0]         in_a,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_illegal
);

    localparam int unsigned SW = $clog2(N);

    localparam logic [2:0] OpSll = 3'd0;
    localparam logic [2:0] OpSrl = 3'd1;
    localparam logic [2:0] OpSra = 3'd2;
    localparam logic [2:0] OpRol = 3'd3;
    localparam logic [2:0] OpRor = 3'd4;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [N-1:0]     s1_a_q, s1_a_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_ill_q, s1_ill_d;
    logic [SW-1:0]    s1_k_q, s1_k_d;
    logic [N-1:0]     s1_m_q, s1_m_d;

    // Stage 2 (output) registers
    logic             s2_valid_q, s2_valid_d;
    logic [N-1:0]     s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_ill_q, s2_ill_d;

    logic             s1_load, s2_load;
    logic [SW-1:0]    k_in;
    logic [N-1:0]     m_in;
    logic             ill_in;
    logic [N-1:0]     rot;
    logic [N-1:0]     s2_calc;

    // Handshake: stage 2 drains/refills, stage 1 refills behind it in the same cycle
    always_comb begin
        s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
        // Held low during reset so upstream never sees a transfer that gets discarded
        in_ready = rst_n & (~s1_valid_q | s2_load);
        s1_load  = in_valid & in_ready;
    end

    // Decode the incoming op into a left-rotate amount and a fill mask
    always_comb begin
        k_in   = in_shamt;
        m_in   = {N{1'b1}};
        ill_in = 1'b0;
        case (in_op)
            OpSll: m_in = {N{1'b1}} << in_shamt;
            OpSrl, OpSra: begin
                k_in = '0 - in_shamt;
                m_in = {N{1'b1}} >> in_shamt;
            end
            OpRol: k_in = in_shamt;
            OpRor: k_in = '0 - in_shamt;
            default: ill_in = 1'b1;
        endcase
    end

    // Stage 1 next state
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_tag_d   = s1_tag_q;
        s1_ill_d   = s1_ill_q;
        s1_k_d     = s1_k_q;
        s1_m_d     = s1_m_q;
        if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_a_d     = in_a;
            s1_tag_d   = in_tag;
            s1_ill_d   = ill_in;
            s1_k_d     = k_in;
            s1_m_d     = m_in;
        end
    end

    // Logarithmic cyclic left shifter on the stage 1 operand
    always_comb begin
        rot = s1_a_q;
        for (int i = 0; i < int'(SW); i++) begin
            if (s1_k_q[i]) begin
                rot = (rot << (1 << i)) | (rot >> (int'(N) - (1 << i)));
            end
        end
    end

    // Mask the rotated value; SRA fills the vacated high bits with the sign
    always_comb begin
        s2_calc = rot & s1_m_q;
        if (s1_op_q == OpSra && s1_a_q[N-1]) begin
            s2_calc = s2_calc | ~s1_m_q;
        end
        if (s1_ill_q) begin
            s2_calc = '0;
        end
    end

    // Stage 2 next state: load on advance, otherwise hold until accepted
    always_comb begin
        s2_valid_d  = s2_valid_q & ~out_ready;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
        s2_ill_d    = s2_ill_q;
        if (s2_load) begin
            s2_valid_d  = 1'b1;
            s2_result_d = s2_calc;
            s2_tag_d    = s1_tag_q;
            s2_ill_d    = s1_ill_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_tag_q    <= '0;
            s1_ill_q    <= 1'b0;
            s1_k_q      <= '0;
            s1_m_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
            s2_ill_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_tag_q    <= s1_tag_d;
            s1_ill_q    <= s1_ill_d;
            s1_k_q      <= s1_k_d;
            s1_m_q      <= s1_m_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
            s2_ill_q    <= s2_ill_d;
        end
    end

    // Outputs come straight from the stage 2 registers
    always_comb begin
        out_valid   = s2_valid_q;
        out_result  = s2_result_q;
        out_tag     = s2_tag_q;
        out_illegal = s2_ill_q;
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe: single ops, a backpressured stream,
// an illegal opcode and a mid-flight reset.
module tb_shift_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [4:0]  in_shamt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    shift_unit_pipe #(.N(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
        .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // Offer one op with out_ready=1 and check the two-edge latency
    task automatic one(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [4:0] sh, input logic [4:0] tag,
                       input logic [31:0] exp, input logic ill);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_a = a; in_shamt = sh; in_tag = tag;
        #1;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_result"}, out_result, exp);
        chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
        chk({nm, "_illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    logic [2:0]  s_op  [10];
    logic [31:0] s_a   [10];
    logic [4:0]  s_sh  [10];
    logic [31:0] s_exp [10];
    int sent, recv, last_recv, occ;

    initial begin
        s_op  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd0};
        s_a   = '{32'h0000_0001, 32'h0000_0001, 32'hF000_0000, 32'hF000_0000, 32'h1234_5678,
                  32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF000_0000, 32'hABCD_0000};
        s_sh  = '{5'd1, 5'd31, 5'd4, 5'd4, 5'd4, 5'd4, 5'd16, 5'd1, 5'd4, 5'd8};
        s_exp = '{32'h0000_0002, 32'h8000_0000, 32'h0F00_0000, 32'hFF00_0000, 32'h2345_6781,
                  32'h8123_4567, 32'h0000_FFFF, 32'hC000_0000, 32'h0000_000F, 32'hCD00_0000};

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_shamt = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        one("sll4", 3'd0, 32'h0000_0001, 5'd4, 5'd3, 32'h0000_0010, 1'b0);
        one("srl31", 3'd1, 32'h8000_0000, 5'd31, 5'd4, 32'h0000_0001, 1'b0);
        one("sra31", 3'd2, 32'h8000_0000, 5'd31, 5'd5, 32'hFFFF_FFFF, 1'b0);
        one("sra4", 3'd2, 32'h7000_0000, 5'd4, 5'd6, 32'h0700_0000, 1'b0);
        one("sra0", 3'd2, 32'hDEAD_BEEF, 5'd0, 5'd7, 32'hDEAD_BEEF, 1'b0);
        one("srl0", 3'd1, 32'hDEAD_BEEF, 5'd0, 5'd8, 32'hDEAD_BEEF, 1'b0);
        one("ror0", 3'd4, 32'hDEAD_BEEF, 5'd0, 5'd9, 32'hDEAD_BEEF, 1'b0);
        one("rol1", 3'd3, 32'h8000_0001, 5'd1, 5'd10, 32'h0000_0003, 1'b0);
        one("ror1", 3'd4, 32'h0000_0001, 5'd1, 5'd11, 32'h8000_0000, 1'b0);
        one("ror8", 3'd4, 32'h1234_5678, 5'd8, 5'd12, 32'h7812_3456, 1'b0);
        one("illegal", 3'd6, 32'hFFFF_FFFF, 5'h1F, 5'h1F, 32'h0000_0000, 1'b1);
        one("after_illegal", 3'd0, 32'h0000_0001, 5'd0, 5'd2, 32'h0000_0001, 1'b0);

        // Stream of 10 ops, out_ready low during cycles 3..7
        sent = 0; recv = 0; last_recv = -1;
        for (int c = 0; c < 40 && recv < 10; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 3 && c <= 7);
            if (sent < 10) begin
                in_valid = 1'b1; in_op = s_op[sent]; in_a = s_a[sent];
                in_shamt = s_sh[sent]; in_tag = 5'(16 + sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            occ = sent - recv;
            chk("stream_in_ready", 32'(in_ready), 32'((occ < 2) || out_ready));
            if (!out_ready) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_result", out_result, s_exp[recv]);
            end
            if (out_valid && out_ready) begin
                chk("stream_result", out_result, s_exp[recv]);
                chk("stream_tag", 32'(out_tag), 32'(16 + recv));
                recv++;
                last_recv = c;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 32'(recv), 32'd10);
        chk("stream_last_cycle", 32'(last_recv), 32'd16);

        // Two ops in flight, then a one-cycle reset
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'h1; in_shamt = 5'd1; in_tag = 5'd1;
        @(posedge clk); #1;
        in_tag = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", out_result, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
            chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Two-stage elastic pipeline implementing all MIPS-style shift and rotate operations for the EX stage of each core.
- Stage 1 latches the operands and converts every operation into a cyclic-left-shift amount.
- Stage 2 feeds the team's N-bit cyclic left shifter (instantiated internally, combinational), then applies the zero/sign-fill mask.
- Sits between the issue/operand-read logic (upstream) and the EX/MEM writeback mux (downstream).

Parameters:
- N, 32, datapath width; power of two, >= 4.
- TAG_W, 5, width of the sideband tag (destination register index) carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  block accepts the operation this cycle.
- in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101–111 illegal.
- in_a  input  N  operand to shift.
- in_shamt  input  $clog2(N)  shift amount.
- in_tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_result  output  N  shifted/rotated value.
- out_tag  output  TAG_W  tag of the result.
- out_illegal  output  1  result came from an illegal opcode.

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - s1_valid=0, s2_valid=0.
  - out_valid=0, out_result=0, out_tag=0, out_illegal=0.
  - Registered data fields reset to 0.
  - in_ready=1 combinationally once reset is released.
- Handshake:
  - A transfer occurs when valid&ready are both high at a rising edge.
  - out_valid/out_result/out_tag/out_illegal stay stable while out_valid=1 and out_ready=0.
  - out_valid is never dropped without a transfer.
- Stage 1 (s1) registers op, a, tag, illegal flag and rotate amount k (width $clog2(N), mod-N arithmetic):
  - SLL/ROL: k=shamt.
  - SRL/SRA/ROR: k=(N-shamt) mod N; shamt=0 gives k=0.
  - s1 also registers fill mask m:
    - SLL: ones at bit positions >= shamt.
    - SRL/SRA: ones at bit positions < N-shamt; all ones when shamt=0.
    - ROL/ROR/illegal: all ones.
- Stage 2 (s2) computes rot = cyclic_left(a, k), then:
  - SLL/SRL/ROL/ROR: result = rot & m.
  - SRA: result = (rot & m) | (~m if a[N-1] else 0).
  - Illegal: result=0, out_illegal=1.
  - out_tag=tag.
- Advance rules:
  - s2_load = s1_valid & (!s2_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = !s1_valid | s2_load. Combinational from out_ready; no combinational path from in_valid to out_valid.
  - Simultaneous s2 drain and s1 refill in the same cycle is supported: full throughput, 1 op/cycle.
- Latency: an op accepted at edge t appears with out_valid=1 after edge t+1 (2 registers), absent backpressure.
- Backpressure: with out_ready=0, the pipe holds up to 2 ops, then in_ready=0. No op is lost or duplicated, and order is preserved.
- Reset mid-operation: all in-flight ops are discarded; nothing is emitted after reset.
- Illegal opcodes occupy a pipeline slot like legal ones and do not stall.

Test Plan:
- SLL a=0x0000_0001 shamt=4; SRL a=0x8000_0000 shamt=31 -> results 0x0000_0010 and 0x0000_0001, each out_valid 2 cycles after acceptance, tags echoed.
- SRA a=0x8000_0000 shamt=31 -> 0xFFFF_FFFF; SRA a=0x7000_0000 shamt=4 -> 0x0700_0000; SRA/SRL/ROR with shamt=0, a=0xDEAD_BEEF -> 0xDEAD_BEEF.
- ROL a=0x8000_0001 shamt=1 -> 0x0000_0003; ROR a=0x0000_0001 shamt=1 -> 0x8000_0000; ROR a=0x1234_5678 shamt=8 -> 0x7812_3456.
- Stream 10 ops back-to-back with out_ready held 0 for cycles 3–7:
  - in_ready drops once 2 ops are held.
  - out_result is stable while stalled.
  - All 10 results emerge in order with correct tags.
  - Throughput is 1/cycle when unstalled.
- in_op=110, a=0xFFFF_FFFF, tag=0x1F -> out_result=0, out_illegal=1, out_tag=0x1F; a following legal op is unaffected (out_illegal=0).
- Two ops in flight, assert rst_n=0 for one cycle -> out_valid=0 next cycle, no stale result ever appears, in_ready=1 after release.
